// File: rtl/vga_dac_pkg.sv
// rtl/vga_dac_pkg.sv - shared sizes, register addresses and sequencer type for the VGA colour DAC
package vga_dac_pkg;

  localparam int DAC_ENTRIES = 256;
  localparam int COMP_W      = 6;
  localparam int RGB_W       = 3 * COMP_W;

  localparam logic [1:0] DAC_MASK   = 2'd0;
  localparam logic [1:0] DAC_RD_IDX = 2'd1;
  localparam logic [1:0] DAC_WR_IDX = 2'd2;
  localparam logic [1:0] DAC_DATA   = 2'd3;

  localparam logic [7:0] DAC_STATE_RD = 8'h03;
  localparam logic [7:0] DAC_STATE_WR = 8'h00;

  typedef enum logic [1:0] {
    CYC_R = 2'd0,
    CYC_G = 2'd1,
    CYC_B = 2'd2
  } dac_cycle_t;

endpackage

// File: rtl/vga_dac_lut.sv
// rtl/vga_dac_lut.sv - 256x18 colour LUT, one write port, registered pixel and CPU read ports
module vga_dac_lut
  import vga_dac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [7:0]       waddr,
  input  logic [RGB_W-1:0] wdata,
  input  logic [7:0]       pix_addr,
  output logic [RGB_W-1:0] pix_rgb,
  input  logic             cpu_en,
  input  logic [7:0]       cpu_addr,
  output logic [RGB_W-1:0] cpu_rgb
);

  logic [RGB_W-1:0] mem [DAC_ENTRIES];

  // Storage is deliberately left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Both ports sample the pre-write contents on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rgb <= '0;
      cpu_rgb <= '0;
    end else begin
      pix_rgb <= mem[pix_addr];
      if (cpu_en) cpu_rgb <= mem[cpu_addr];
    end
  end

endmodule

// File: rtl/vga_dac_regs.sv
// rtl/vga_dac_regs.sv - VGA DAC register file and pixel LUT; VGA_DAC_PEL_MASK_EN builds the PEL mask
module vga_dac_regs
  import vga_dac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] index,
  output logic [5:0] red,
  output logic [5:0] green,
  output logic [5:0] blue,
  input  logic [1:0] address,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] write_data,
  output logic [7:0] read_data
);

  logic [7:0]        write_index;
  logic [7:0]        read_index;
  dac_cycle_t        write_cycle;
  dac_cycle_t        read_cycle;
  logic [COMP_W-1:0] stage_r;
  logic [COMP_W-1:0] stage_g;
  logic              rd_mode;

  logic              rd_sel_data;
  dac_cycle_t        rd_comp;
  logic [7:0]        rd_reg;

  logic [7:0]        pix_addr;
  logic [7:0]        mask_rd;
  logic              lut_we;
  logic              cpu_rd_en;
  logic [RGB_W-1:0]  lut_wdata;
  logic [RGB_W-1:0]  pix_rgb;
  logic [RGB_W-1:0]  cpu_rgb;

`ifdef VGA_DAC_PEL_MASK_EN
  logic [7:0] pel_mask;
  assign pix_addr = index & pel_mask;
  assign mask_rd  = pel_mask;
`else
  assign pix_addr = index;
  assign mask_rd  = 8'hFF;
`endif

  assign lut_we    = write && (address == DAC_DATA) && (write_cycle == CYC_B);
  assign lut_wdata = {stage_r, stage_g, write_data[COMP_W-1:0]};
  assign cpu_rd_en = read && !write && (address == DAC_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_index <= '0;
      read_index  <= '0;
      write_cycle <= CYC_R;
      read_cycle  <= CYC_R;
      stage_r     <= '0;
      stage_g     <= '0;
      rd_mode     <= 1'b0;
      rd_sel_data <= 1'b0;
      rd_comp     <= CYC_R;
      rd_reg      <= '0;
`ifdef VGA_DAC_PEL_MASK_EN
      pel_mask    <= 8'hFF;
`endif
    end else if (write) begin
      case (address)
        DAC_MASK: begin
`ifdef VGA_DAC_PEL_MASK_EN
          pel_mask <= write_data;
`endif
        end
        DAC_RD_IDX: begin
          read_index <= write_data;
          read_cycle <= CYC_R;
          rd_mode    <= 1'b1;
        end
        DAC_WR_IDX: begin
          write_index <= write_data;
          write_cycle <= CYC_R;
          rd_mode     <= 1'b0;
        end
        DAC_DATA: begin
          case (write_cycle)
            CYC_R: begin
              stage_r     <= write_data[COMP_W-1:0];
              write_cycle <= CYC_G;
            end
            CYC_G: begin
              stage_g     <= write_data[COMP_W-1:0];
              write_cycle <= CYC_B;
            end
            default: begin
              write_index <= write_index + 8'd1;
              write_cycle <= CYC_R;
            end
          endcase
        end
      endcase
    end else if (read) begin
      // Data reads take their value from the LUT CPU port register; others from rd_reg.
      rd_sel_data <= (address == DAC_DATA);
      rd_comp     <= read_cycle;
      case (address)
        DAC_MASK:   rd_reg <= mask_rd;
        DAC_RD_IDX: rd_reg <= rd_mode ? DAC_STATE_RD : DAC_STATE_WR;
        DAC_WR_IDX: rd_reg <= write_index;
        DAC_DATA: begin
          case (read_cycle)
            CYC_R:   read_cycle <= CYC_G;
            CYC_G:   read_cycle <= CYC_B;
            default: begin
              read_index <= read_index + 8'd1;
              read_cycle <= CYC_R;
            end
          endcase
        end
      endcase
    end
  end

  always_comb begin
    read_data = rd_reg;
    if (rd_sel_data) begin
      case (rd_comp)
        CYC_R:   read_data = {2'b00, cpu_rgb[3*COMP_W-1:2*COMP_W]};
        CYC_G:   read_data = {2'b00, cpu_rgb[2*COMP_W-1:COMP_W]};
        default: read_data = {2'b00, cpu_rgb[COMP_W-1:0]};
      endcase
    end
  end

  vga_dac_lut u_lut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (lut_we),
    .waddr    (write_index),
    .wdata    (lut_wdata),
    .pix_addr (pix_addr),
    .pix_rgb  (pix_rgb),
    .cpu_en   (cpu_rd_en),
    .cpu_addr (read_index),
    .cpu_rgb  (cpu_rgb)
  );

  assign red   = pix_rgb[3*COMP_W-1:2*COMP_W];
  assign green = pix_rgb[2*COMP_W-1:COMP_W];
  assign blue  = pix_rgb[COMP_W-1:0];

endmodule

// File: tb/tb_vga_dac_regs.sv
// tb/tb_vga_dac_regs.sv - directed self-checking bench for vga_dac_regs
module tb_vga_dac_regs;

  logic       clk;
  logic       rst_n;
  logic [7:0] index;
  logic [5:0] red, green, blue;
  logic [1:0] address;
  logic       write;
  logic       read;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic [17:0] rgb;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  assign rgb = {red, green, blue};

  vga_dac_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (index),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .address    (address),
    .write      (write),
    .read       (read),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    address = a; write_data = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check(tag, {24'd0, read_data}, {24'd0, exp});
  endtask

  task automatic pix_chk(input string tag, input logic [7:0] idx, input logic [17:0] exp);
    index = idx;
    @(negedge clk);
    check(tag, {14'd0, rgb}, {14'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; index = 8'h00; address = 2'd0;
    write = 1'b0; read = 1'b0; write_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_rgb", {14'd0, rgb}, 32'd0);
    check("reset_read_data", {24'd0, read_data}, 32'd0);
    rd_chk("reset_mask", 2'd0, 8'hFF);
    rd_chk("reset_state", 2'd1, 8'h00);
    rd_chk("reset_wr_idx", 2'd2, 8'h00);

    // write with index wrap 0xFF -> 0x00
    cpu_wr(2'd2, 8'hFF);
    cpu_wr(2'd3, 8'h3F); cpu_wr(2'd3, 8'h00); cpu_wr(2'd3, 8'h15);
    cpu_wr(2'd3, 8'h01); cpu_wr(2'd3, 8'h02); cpu_wr(2'd3, 8'h03);
    pix_chk("pix_ff", 8'hFF, {6'h3F, 6'h00, 6'h15});
    pix_chk("pix_00", 8'h00, {6'h01, 6'h02, 6'h03});
    rd_chk("wr_idx_wrap", 2'd2, 8'h01);

    // read-back with wrap
    cpu_wr(2'd1, 8'hFF);
    rd_chk("rb0", 2'd3, 8'h3F);
    rd_chk("rb1", 2'd3, 8'h00);
    rd_chk("rb2", 2'd3, 8'h15);
    rd_chk("rb3", 2'd3, 8'h01);
    rd_chk("rb4", 2'd3, 8'h02);
    rd_chk("rb5", 2'd3, 8'h03);
    rd_chk("state_rd", 2'd1, 8'h03);

    // mask test; high bits of data writes are dropped
    cpu_wr(2'd2, 8'h05);
    cpu_wr(2'd3, 8'hCA); cpu_wr(2'd3, 8'h0B); cpu_wr(2'd3, 8'h4C);
    cpu_wr(2'd2, 8'hF5);
    cpu_wr(2'd3, 8'h11); cpu_wr(2'd3, 8'h22); cpu_wr(2'd3, 8'h33);
    rd_chk("state_wr", 2'd1, 8'h00);
    pix_chk("pix_05", 8'h05, {6'h0A, 6'h0B, 6'h0C});
    cpu_wr(2'd0, 8'h0F);
`ifdef VGA_DAC_PEL_MASK_EN
    pix_chk("pix_masked", 8'hF5, {6'h0A, 6'h0B, 6'h0C});
    rd_chk("mask_rd", 2'd0, 8'h0F);
`else
    pix_chk("pix_unmasked", 8'hF5, {6'h11, 6'h22, 6'h33});
    rd_chk("mask_rd", 2'd0, 8'hFF);
`endif
    cpu_wr(2'd0, 8'hFF);

    // write/read priority and pixel collision
    cpu_wr(2'd2, 8'h10);
    cpu_wr(2'd3, 8'h07); cpu_wr(2'd3, 8'h08); cpu_wr(2'd3, 8'h09);
    rd_chk("wr_idx_11", 2'd2, 8'h11);
    cpu_wr(2'd2, 8'h10);
    cpu_wr(2'd3, 8'h01);
    address = 2'd3; write_data = 8'h02; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    check("wr_rd_hold", {24'd0, read_data}, 32'h11);
    index = 8'h10; address = 2'd3; write_data = 8'h03; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("pix_collide_old", {14'd0, rgb}, {14'd0, 6'h07, 6'h08, 6'h09});
    @(negedge clk);
    check("pix_collide_new", {14'd0, rgb}, {14'd0, 6'h01, 6'h02, 6'h03});
    cpu_wr(2'd1, 8'h10);
    rd_chk("rb_10_r", 2'd3, 8'h01);
    rd_chk("rb_10_g", 2'd3, 8'h02);

    // reset mid-sequence abandons staged R/G
    cpu_wr(2'd3, 8'h2A); cpu_wr(2'd3, 8'h2B);
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", {14'd0, rgb}, 32'd0);
    check("midrst_read_data", {24'd0, read_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("midrst_wr_idx", 2'd2, 8'h00);
    cpu_wr(2'd2, 8'h20);
    cpu_wr(2'd3, 8'h1A); cpu_wr(2'd3, 8'h1B); cpu_wr(2'd3, 8'h1C);
    pix_chk("pix_20", 8'h20, {6'h1A, 6'h1B, 6'h1C});
    rd_chk("wr_idx_21", 2'd2, 8'h21);
    cpu_wr(2'd1, 8'h20);
    rd_chk("rb_20_r", 2'd3, 8'h1A);
    rd_chk("rb_20_g", 2'd3, 8'h1B);
    rd_chk("rb_20_b", 2'd3, 8'h1C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
